// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use hazard controller for the in-order pipeline. Each architectural
//   register has a small countdown that is loaded with LOAD_LAT when a load
//   targeting it issues and is cleared when an ALU writer of the same register
//   issues. A decoded instruction stalls while any source it reads still has a
//   non-zero countdown. A taken branch in EX overrides the stall and flushes.
//
//   Optional feature macro: HAZARD_STALL_COUNTER_EN (stalled-cycle counter).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   id_valid            decode holds a real instruction
//   id_src/id_src_used  NSRC packed source indices and their read enables
//   id_rd/id_regwrite   destination register and write enable
//   id_memread          ID instruction is a load
//   ex_br_taken         branch resolved taken in EX
//   stall               load-use stall (combinational)
//   pc_write_enable     PC write enable
//   if_id_write_enable  IF/ID write enable
//   id_ex_bubble        zero ID/EX control
//   if_id_flush         squash IF/ID on the next edge
//   stall_count         stalled-cycle count (0 when the counter is compiled out)

// One scoreboard entry: countdown of cycles until the register's load data
// can be forwarded.
module hazard_sb_slot #(
    parameter int CW       = 1,
    parameter int LOAD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_load,
    input  logic          set_alu,
    output logic [CW-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (set_load)
            cnt <= CW'(LOAD_LAT);
        else if (set_alu)
            cnt <= '0;  // younger ALU writer supersedes the pending load
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end
endmodule

module hazard_scoreboard #(
    parameter int NREG        = 32,
    parameter int ZERO_REG    = 31,
    parameter int LOAD_LAT    = 1,
    parameter int NSRC        = 2,
    parameter int STALL_CNT_W = 32,
    localparam int RW         = $clog2(NREG),
    localparam int CW         = $clog2(LOAD_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NSRC*RW-1:0]     id_src,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [RW-1:0]          id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   ex_br_taken,
    output logic                   stall,
    output logic                   pc_write_enable,
    output logic                   if_id_write_enable,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic [STALL_CNT_W-1:0] stall_count
);
    logic [NREG-1:0][CW-1:0] cnt;
    logic [NSRC-1:0]         hit;
    logic                    issue;

    // A destination index >= NREG matches no slot below, so it never issues.
    assign issue = id_valid & ~stall & ~ex_br_taken & id_regwrite &
                   (id_rd != RW'(ZERO_REG));

    for (genvar r = 0; r < NREG; r++) begin : g_slot
        if (r == ZERO_REG) begin : g_zero
            assign cnt[r] = '0;
        end else begin : g_track
            logic sel;
            assign sel = issue & (id_rd == RW'(r));
            hazard_sb_slot #(.CW(CW), .LOAD_LAT(LOAD_LAT)) u_slot (
                .clk      (clk),
                .reset    (reset),
                .set_load (sel & id_memread),
                .set_alu  (sel & ~id_memread),
                .cnt      (cnt[r])
            );
        end
    end

    // Source lookup by compare against every slot: an index >= NREG matches
    // nothing and so behaves as an unused source. The zero register's slot is
    // tied to 0, so XZR never hits.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NSRC; k++) begin
            for (int r = 0; r < NREG; r++) begin
                if (id_src[k*RW +: RW] == RW'(r) && cnt[r] != '0)
                    hit[k] = 1'b1;
            end
            hit[k] = hit[k] & id_valid & id_src_used[k];
        end
    end

    assign stall              = (|hit) & ~ex_br_taken & ~reset;
    assign pc_write_enable    = ~stall | ex_br_taken;
    assign if_id_write_enable = ~stall | ex_br_taken;
    assign id_ex_bubble       = ~reset & (stall | ex_br_taken);
    assign if_id_flush        = ~reset & ex_br_taken;

`ifdef HAZARD_STALL_COUNTER_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    // Reads as zero for the whole reset cycle, not just after the edge.
    assign stall_count = reset ? '0 : stall_cnt_q;
`else
    assign stall_count = '0;
`endif
endmodule
